// File: rtl/ch_trigger_stop.sv
// ============================================================================
// Module   : ch_trigger_stop (with types_pkg)
// Purpose  : Per-channel trigger acceptance, post-trigger delay and stop-address capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package types_pkg;
    typedef enum logic [2:0] {
        STATE_STOPPED  = 3'd0,
        STATE_INIT     = 3'd1,
        STATE_SAMPLING = 3'd2,
        STATE_READOUT  = 3'd3,
        STATE_CALIB    = 3'd4
    } state_t;
endpackage

module ch_trigger_stop
    import types_pkg::*;
(
    input  logic        FCLK,
    input  logic        RST,
    input  logic        trigger,
    input  logic        INST_START,
    input  state_t      current_state,
    input  logic [9:0]  CE,
    input  logic [7:0]  POST_TRIG_DELAY,
    input  logic        TRIG_CLEAR,
    output logic        TRIG_STOP,
    output logic [9:0]  STOP_ADDR,
    output logic        TRIG_VALID,
    output logic        TRIG_MISSED
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;
    localparam logic [1:0] S_HELD  = 2'd3;

    logic [1:0] r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync3;
    logic [7:0] r_cnt;
    logic       r_stop;
    logic       r_valid;
    logic       r_missed;
    logic [9:0] r_stop_addr;

    logic       w_active;
    logic       w_edge;

    assign w_active = !(current_state inside {STATE_STOPPED, STATE_INIT, STATE_READOUT});
    // Rising edge seen on the synchronised trigger; a held-high level yields one edge.
    assign w_edge   = r_sync2 & ~r_sync3;

    always_ff @(posedge FCLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_cnt       <= 8'd0;
            r_stop      <= 1'b0;
            r_valid     <= 1'b0;
            r_missed    <= 1'b0;
            r_stop_addr <= 10'h000;
        end else begin
            r_sync1 <= trigger;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            case (r_state)
                S_IDLE: begin
                    if (INST_START && w_active) begin
                        r_state  <= S_ARMED;
                        r_missed <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (!w_active) begin
                        r_state <= S_IDLE;
                    end else if (w_edge) begin
                        r_state <= S_DELAY;
                        r_cnt   <= POST_TRIG_DELAY;
                    end
                end
                S_DELAY: begin
                    if (w_edge) begin
                        r_missed <= 1'b1;
                    end
                    if (!w_active) begin
                        r_state <= S_IDLE;
                        r_stop  <= 1'b0;
                        r_valid <= 1'b0;
                    end else if (r_cnt == 8'd0) begin
                        r_state     <= S_HELD;
                        r_stop      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_stop_addr <= CE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HELD: begin
                    if (w_edge) begin
                        r_missed <= 1'b1;
                    end
                    // STOP_ADDR is deliberately kept so readout can still use it after re-arm.
                    if (TRIG_CLEAR || current_state == STATE_INIT) begin
                        r_state <= S_IDLE;
                        r_stop  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TRIG_STOP   = r_stop;
    assign TRIG_VALID  = r_valid;
    assign TRIG_MISSED = r_missed;
    assign STOP_ADDR   = r_stop_addr;

endmodule

`default_nettype wire

// File: tb/tb_ch_trigger_stop.sv
// ============================================================================
// Module   : tb_ch_trigger_stop
// Purpose  : Scoreboard-driven self-checking bench for ch_trigger_stop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ch_trigger_stop;
    import types_pkg::*;

    logic        FCLK;
    logic        RST;
    logic        trigger;
    logic        INST_START;
    state_t      current_state;
    logic [9:0]  CE;
    logic [7:0]  POST_TRIG_DELAY;
    logic        TRIG_CLEAR;
    logic        TRIG_STOP;
    logic [9:0]  STOP_ADDR;
    logic        TRIG_VALID;
    logic        TRIG_MISSED;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         n_cmp;
    int         n_err;
    int         stop_rises;
    logic       prev_stop;
    logic [9:0] ce_base;

    ch_trigger_stop dut (
        .FCLK            (FCLK),
        .RST             (RST),
        .trigger         (trigger),
        .INST_START      (INST_START),
        .current_state   (current_state),
        .CE              (CE),
        .POST_TRIG_DELAY (POST_TRIG_DELAY),
        .TRIG_CLEAR      (TRIG_CLEAR),
        .TRIG_STOP       (TRIG_STOP),
        .STOP_ADDR       (STOP_ADDR),
        .TRIG_VALID      (TRIG_VALID),
        .TRIG_MISSED     (TRIG_MISSED)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    initial cyc = 0;
    always @(posedge FCLK) cyc <= cyc + 1;

    // CE seen at edge e is ce_base + (e - 1).
    always @(negedge FCLK) begin
        CE = ce_base + cyc[9:0];
        if (TRIG_STOP === 1'b1 && prev_stop !== 1'b1) stop_rises++;
        prev_stop = TRIG_STOP;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge FCLK);
    endtask

    task automatic arm();
        INST_START = 1'b1;
        tick(1);
        INST_START = 1'b0;
        tick(1);
    endtask

    // Called at a negedge; n is the first edge that samples trigger high.
    task automatic pulse_trigger(input int len, output int n);
        trigger = 1'b1;
        n = cyc + 1;
        tick(len);
        trigger = 1'b0;
    endtask

    task automatic wait_stop(input int budget, output int at, output bit seen);
        seen = 1'b0;
        at   = -1;
        for (int t = 0; t < budget; t++) begin
            if (TRIG_STOP === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
            @(negedge FCLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(3);
        n_cmp++; if (TRIG_STOP !== 1'b0) begin n_err++; $display("FAIL reset_stop: got %b want 0", TRIG_STOP); end
        n_cmp++; if (TRIG_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", TRIG_VALID); end
        n_cmp++; if (TRIG_MISSED !== 1'b0) begin n_err++; $display("FAIL reset_missed: got %b want 0", TRIG_MISSED); end
        n_cmp++; if (STOP_ADDR !== 10'h000) begin n_err++; $display("FAIL reset_addr: got %h want 000", STOP_ADDR); end
        RST = 1'b0;
        tick(2);
    endtask

    task automatic test_delay4();
        int n, at; bit seen; exp_t e;
        current_state   = STATE_SAMPLING;
        POST_TRIG_DELAY = 8'd4;
        tick(1);
        arm();
        tick(3);
        ce_base = 10'h120 - 10'(cyc + 1 + 6);
        pulse_trigger(2, n);
        sb.push_back('{n + 3 + 4, 10'(ce_base + 10'(n + 2 + 4))});
        wait_stop(40, at, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || at != e.cyc) begin n_err++; $display("FAIL d4_latency: stop at cycle %0d want %0d", at, e.cyc); end
        n_cmp++; if (STOP_ADDR !== e.addr || STOP_ADDR !== 10'h120) begin n_err++; $display("FAIL d4_addr: got %h want 120", STOP_ADDR); end
        n_cmp++; if (TRIG_VALID !== 1'b1) begin n_err++; $display("FAIL d4_valid: got %b want 1", TRIG_VALID); end
        n_cmp++; if (TRIG_MISSED !== 1'b0) begin n_err++; $display("FAIL d4_missed: got %b want 0", TRIG_MISSED); end
    endtask

    task automatic test_missed_in_held();
        int n;
        tick(3);
        pulse_trigger(2, n);
        tick(5);
        n_cmp++; if (TRIG_MISSED !== 1'b1) begin n_err++; $display("FAIL held_missed: got %b want 1", TRIG_MISSED); end
        n_cmp++; if (STOP_ADDR !== 10'h120) begin n_err++; $display("FAIL held_addr: got %h want 120", STOP_ADDR); end
        n_cmp++; if (TRIG_STOP !== 1'b1) begin n_err++; $display("FAIL held_stop: got %b want 1", TRIG_STOP); end
    endtask

    task automatic test_clear_rearm_d0();
        int n, at; bit seen; exp_t e;
        TRIG_CLEAR = 1'b1;
        tick(1);
        TRIG_CLEAR = 1'b0;
        n_cmp++; if (TRIG_STOP !== 1'b0) begin n_err++; $display("FAIL clear_stop: got %b want 0", TRIG_STOP); end
        n_cmp++; if (TRIG_VALID !== 1'b0) begin n_err++; $display("FAIL clear_valid: got %b want 0", TRIG_VALID); end
        n_cmp++; if (STOP_ADDR !== 10'h120) begin n_err++; $display("FAIL clear_addr: got %h want 120", STOP_ADDR); end
        n_cmp++; if (TRIG_MISSED !== 1'b1) begin n_err++; $display("FAIL clear_missed_kept: got %b want 1", TRIG_MISSED); end
        tick(2);
        arm();
        n_cmp++; if (TRIG_MISSED !== 1'b0) begin n_err++; $display("FAIL rearm_missed: got %b want 0", TRIG_MISSED); end
        POST_TRIG_DELAY = 8'd0;
        ce_base = 10'h055;
        tick(2);
        pulse_trigger(2, n);
        sb.push_back('{n + 3, 10'(ce_base + 10'(n + 2))});
        wait_stop(20, at, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || at != e.cyc) begin n_err++; $display("FAIL d0_latency: stop at cycle %0d want %0d", at, e.cyc); end
        n_cmp++; if (STOP_ADDR !== e.addr) begin n_err++; $display("FAIL d0_addr: got %h want %h", STOP_ADDR, e.addr); end
        tick(2);
        TRIG_CLEAR = 1'b1;
        tick(1);
        TRIG_CLEAR = 1'b0;
        tick(2);
    endtask

    task automatic test_abort_readout();
        int n, rises0;
        POST_TRIG_DELAY = 8'd255;
        arm();
        tick(2);
        rises0 = stop_rises;
        pulse_trigger(2, n);
        // Counter reads 100 during the cycle before edge n+158.
        while (cyc < n + 157) tick(1);
        current_state = STATE_READOUT;
        tick(150);
        n_cmp++; if (stop_rises != rises0) begin n_err++; $display("FAIL abort_no_stop: rises %0d want %0d", stop_rises, rises0); end
        n_cmp++; if (TRIG_VALID !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", TRIG_VALID); end
        current_state   = STATE_SAMPLING;
        POST_TRIG_DELAY = 8'd1;
        tick(2);
        pulse_trigger(2, n);
        tick(20);
        n_cmp++; if (stop_rises != rises0) begin n_err++; $display("FAIL abort_is_idle: rises %0d want %0d", stop_rises, rises0); end
    endtask

    task automatic test_reset_mid_delay();
        int n, at, rises0; bit seen; exp_t e;
        POST_TRIG_DELAY = 8'd20;
        arm();
        tick(2);
        trigger = 1'b1;
        tick(8);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        n_cmp++; if ({TRIG_STOP, TRIG_VALID, TRIG_MISSED} !== 3'b000) begin n_err++; $display("FAIL rst_mid_flags: got %b want 000", {TRIG_STOP, TRIG_VALID, TRIG_MISSED}); end
        n_cmp++; if (STOP_ADDR !== 10'h000) begin n_err++; $display("FAIL rst_mid_addr: got %h want 000", STOP_ADDR); end
        tick(5);
        arm();
        rises0 = stop_rises;
        tick(40);
        n_cmp++; if (stop_rises != rises0) begin n_err++; $display("FAIL rst_held_level: rises %0d want %0d", stop_rises, rises0); end
        trigger = 1'b0;
        tick(3);
        ce_base = 10'h3F0;
        trigger = 1'b1;
        n = cyc + 1;
        sb.push_back('{n + 3 + 20, 10'(ce_base + 10'(n + 2 + 20))});
        wait_stop(60, at, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || at != e.cyc) begin n_err++; $display("FAIL rst_fresh_edge: stop at cycle %0d want %0d", at, e.cyc); end
        n_cmp++; if (STOP_ADDR !== e.addr) begin n_err++; $display("FAIL rst_fresh_addr: got %h want %h", STOP_ADDR, e.addr); end
        trigger = 1'b0;
        TRIG_CLEAR = 1'b1;
        tick(1);
        TRIG_CLEAR = 1'b0;
        tick(3);
    endtask

    task automatic test_idle_init_level();
        int n, at, rises0; bit seen; exp_t e;
        rises0 = stop_rises;
        pulse_trigger(2, n);
        tick(20);
        n_cmp++; if (stop_rises != rises0) begin n_err++; $display("FAIL idle_trigger: rises %0d want %0d", stop_rises, rises0); end
        current_state = STATE_INIT;
        arm();
        pulse_trigger(2, n);
        tick(20);
        n_cmp++; if (stop_rises != rises0) begin n_err++; $display("FAIL init_trigger: rises %0d want %0d", stop_rises, rises0); end
        current_state   = STATE_SAMPLING;
        POST_TRIG_DELAY = 8'd2;
        arm();
        tick(2);
        trigger = 1'b1;
        n = cyc + 1;
        sb.push_back('{n + 5, 10'(ce_base + 10'(n + 4))});
        wait_stop(30, at, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || at != e.cyc) begin n_err++; $display("FAIL level_latency: stop at cycle %0d want %0d", at, e.cyc); end
        while (cyc < n + 50) tick(1);
        trigger = 1'b0;
        tick(3);
        n_cmp++; if (stop_rises != rises0 + 1) begin n_err++; $display("FAIL level_once: rises %0d want %0d", stop_rises, rises0 + 1); end
        n_cmp++; if (TRIG_MISSED !== 1'b0) begin n_err++; $display("FAIL level_missed: got %b want 0", TRIG_MISSED); end
        current_state = STATE_INIT;
        tick(1);
        n_cmp++; if (TRIG_STOP !== 1'b0) begin n_err++; $display("FAIL init_exit: got %b want 0", TRIG_STOP); end
        current_state = STATE_SAMPLING;
        tick(2);
    endtask

    task automatic test_back_to_back();
        int n, at; bit seen; exp_t e;
        POST_TRIG_DELAY = 8'd0;
        arm();
        tick(2);
        pulse_trigger(2, n);
        sb.push_back('{n + 3, 10'(ce_base + 10'(n + 2))});
        wait_stop(20, at, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || at != e.cyc) begin n_err++; $display("FAIL b2b_latency: stop at cycle %0d want %0d", at, e.cyc); end
        tick(3);
        trigger = 1'b1;
        n = cyc + 1;
        while (cyc < n + 1) tick(1);
        TRIG_CLEAR = 1'b1;
        tick(1);
        TRIG_CLEAR = 1'b0;
        trigger = 1'b0;
        n_cmp++; if (TRIG_STOP !== 1'b0) begin n_err++; $display("FAIL b2b_clear_stop: got %b want 0", TRIG_STOP); end
        n_cmp++; if (TRIG_MISSED !== 1'b1) begin n_err++; $display("FAIL b2b_missed: got %b want 1", TRIG_MISSED); end
        n_cmp++; if (STOP_ADDR !== e.addr) begin n_err++; $display("FAIL b2b_addr: got %h want %h", STOP_ADDR, e.addr); end
        tick(2);
        arm();
        n_cmp++; if (TRIG_MISSED !== 1'b0) begin n_err++; $display("FAIL b2b_rearm_missed: got %b want 0", TRIG_MISSED); end
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        stop_rises      = 0;
        prev_stop       = 1'b0;
        ce_base         = 10'h000;
        CE              = 10'h000;
        RST             = 1'b1;
        trigger         = 1'b0;
        INST_START      = 1'b0;
        TRIG_CLEAR      = 1'b0;
        POST_TRIG_DELAY = 8'd0;
        current_state   = STATE_STOPPED;

        test_reset();
        test_delay4();
        test_missed_in_held();
        test_clear_rearm_d0();
        test_abort_readout();
        test_reset_mid_delay();
        test_idle_init_level();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
